sd_clock_monitor: RTL and testbench

- Receiving-side counterpart of the SD clock divider: watches the divided SD clock from the AXI_CLOCK domain and recovers the divisor that produced it.
- Qualifies the clock with lock, loss and mismatch flags, so the host controller can check that sd_clk is running at the programmed rate before it issues CMD traffic.
- Sits beside the divider in the eMMC host controller and feeds the present-state/status logic.

---
 rtl/sd_clk_pkg.sv | 23 ++
 rtl/sd_sync_edge.sv | 35 +++
 rtl/sd_clock_monitor.sv | 137 +++++++++++++
 tb/tb_sd_clock_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_clk_pkg.sv
// ============================================================================
// Module  : sd_clk_pkg
// Brief   : Shared types and constants for the SD clock monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_clk_pkg;

  localparam int CNT_W   = 10;
  localparam int DIV_MAX = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_TRACK   = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_LOST    = 3'd4
  } sd_mon_state_e;

endpackage

`default_nettype wire

// File: rtl/sd_sync_edge.sv
// ============================================================================
// Module  : sd_sync_edge
// Brief   : Two-flop synchronizer with both-edge toggle detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_sync_edge (
  input  logic AXI_CLOCK,
  input  logic AXI_RST,
  input  logic i_async,
  output logic o_toggle
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
    if (!AXI_RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_toggle = r_sync2 ^ r_prev;

endmodule

`default_nettype wire

// File: rtl/sd_clock_monitor.sv
// ============================================================================
// Module  : sd_clock_monitor
// Brief   : Recovers the SD clock divisor and qualifies lock / loss / mismatch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_clock_monitor
  import sd_clk_pkg::*;
#(
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic       AXI_CLOCK,
  input  logic       AXI_RST,
  input  logic       sd_clk_in,
  input  logic [7:0] exp_divisor,
  output logic [7:0] meas_divisor,
  output logic       meas_valid,
  output logic       locked,
  output logic       clk_lost,
  output logic       div_mismatch
);

  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_div_max    = CNT_W'(DIV_MAX);
  localparam logic [3:0]       c_lock_count = 4'(LOCK_COUNT);

  logic             w_toggle;
  logic [CNT_W-1:0] r_cnt;
  sd_mon_state_e    r_state;
  sd_mon_state_e    w_next_state;
  logic [3:0]       r_match_cnt;
  logic [3:0]       w_next_match;
  logic [7:0]       r_meas;
  logic [7:0]       w_next_meas;
  logic             w_meas_upd;
  logic             w_in_range;
  logic             w_timeout;
  logic [7:0]       w_sample;

  sd_sync_edge u_sync (
    .AXI_CLOCK (AXI_CLOCK),
    .AXI_RST   (AXI_RST),
    .i_async   (sd_clk_in),
    .o_toggle  (w_toggle)
  );

  // Interval counter: value at a toggle is the half-period minus one.
  always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
    if (!AXI_RST) begin
      r_cnt <= '0;
    end else if (w_toggle) begin
      r_cnt <= '0;
    end else if (r_cnt != c_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_in_range = (r_cnt <= c_div_max);
  assign w_sample   = r_cnt[7:0];
  assign w_timeout  = !w_toggle && (r_cnt == c_timeout_m1);

  always_comb begin
    w_next_state = r_state;
    w_next_match = r_match_cnt;
    w_next_meas  = r_meas;
    w_meas_upd   = 1'b0;
    if (w_toggle) begin
      case (r_state)
        ST_IDLE, ST_LOST: begin
          w_next_state = ST_ACQUIRE;
          w_next_match = 4'd0;
        end
        ST_ACQUIRE: begin
          if (w_in_range) begin
            w_next_meas  = w_sample;
            w_meas_upd   = 1'b1;
            w_next_match = 4'd1;
            w_next_state = ST_TRACK;
          end
        end
        ST_TRACK, ST_LOCKED: begin
          if (!w_in_range) begin
            w_next_state = ST_ACQUIRE;
            w_next_match = 4'd0;
          end else begin
            w_next_meas = w_sample;
            w_meas_upd  = 1'b1;
            if (w_sample != r_meas) begin
              w_next_match = 4'd1;
              w_next_state = ST_TRACK;
            end else if (r_state == ST_TRACK) begin
              w_next_match = r_match_cnt + 4'd1;
              if (w_next_match >= c_lock_count) begin
                w_next_state = ST_LOCKED;
              end
            end
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_match = 4'd0;
        end
      endcase
    end else if (w_timeout && (r_state != ST_LOST)) begin
      w_next_state = ST_LOST;
      w_next_match = 4'd0;
    end
  end

  always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
    if (!AXI_RST) begin
      r_state      <= ST_IDLE;
      r_match_cnt  <= 4'd0;
      r_meas       <= 8'd0;
      meas_valid   <= 1'b0;
      locked       <= 1'b0;
      clk_lost     <= 1'b0;
      div_mismatch <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_match_cnt  <= w_next_match;
      r_meas       <= w_next_meas;
      meas_valid   <= w_meas_upd;
      locked       <= (w_next_state == ST_LOCKED);
      clk_lost     <= (w_next_state == ST_LOST);
      div_mismatch <= locked && (r_meas != exp_divisor);
    end
  end

  assign meas_divisor = r_meas;

endmodule

`default_nettype wire

// File: tb/tb_sd_clock_monitor.sv
// ============================================================================
// Module  : tb_sd_clock_monitor
// Brief   : Self-checking bench for sd_clock_monitor against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sd_clock_monitor;

  localparam int LOCK_COUNT     = 4;
  localparam int TIMEOUT_CYCLES = 300;

  logic       AXI_CLOCK   = 1'b0;
  logic       AXI_RST     = 1'b0;
  logic       sd_clk_in   = 1'b0;
  logic [7:0] exp_divisor = 8'd0;
  logic [7:0] meas_divisor;
  logic       meas_valid;
  logic       locked;
  logic       clk_lost;
  logic       div_mismatch;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  always #5 AXI_CLOCK = ~AXI_CLOCK;

  sd_clock_monitor #(
    .LOCK_COUNT     (LOCK_COUNT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .AXI_CLOCK    (AXI_CLOCK),
    .AXI_RST      (AXI_RST),
    .sd_clk_in    (sd_clk_in),
    .exp_divisor  (exp_divisor),
    .meas_divisor (meas_divisor),
    .meas_valid   (meas_valid),
    .locked       (locked),
    .clk_lost     (clk_lost),
    .div_mismatch (div_mismatch)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: an sd_clk_in edge is seen two clocks after it is first sampled;
  // the sample is the number of quiet clocks between seen edges.
  bit m_hist[$];
  int m_phase;    // 0 waiting for first edge, 1 acquiring, 2 tracking
  int m_matches;
  int m_quiet;
  int m_md;
  bit m_mv, m_lk, m_lost, m_mm;

  task automatic m_reset();
    m_hist = '{1'b0, 1'b0, 1'b0};
    m_phase = 0; m_matches = 0; m_quiet = 0; m_md = 0;
    m_mv = 0; m_lk = 0; m_lost = 0; m_mm = 0;
  endtask

  task automatic m_step();
    bit tog;
    bit prev_lk;
    int prev_md;
    int smp;
    prev_lk = m_lk;
    prev_md = m_md;
    m_hist.push_back(sd_clk_in);
    if (m_hist.size() > 6) void'(m_hist.pop_front());
    tog = m_hist[m_hist.size()-3] ^ m_hist[m_hist.size()-4];
    smp = m_quiet;
    m_mv = 0;
    if (tog) begin
      if (m_lost) begin
        m_lost = 0; m_phase = 1; m_matches = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (smp > 255) begin
        m_phase = 1; m_matches = 0; m_lk = 0;
      end else begin
        m_mv = 1;
        if (m_phase == 2 && smp == m_md) m_matches++;
        else m_matches = 1;
        m_md = smp;
        m_phase = 2;
        m_lk = (m_matches >= LOCK_COUNT);
      end
      m_quiet = 0;
    end else begin
      if (m_quiet == TIMEOUT_CYCLES - 1 && !m_lost) begin
        m_lost = 1; m_lk = 0; m_matches = 0;
      end
      if (m_quiet < TIMEOUT_CYCLES) m_quiet++;
    end
    m_mm = prev_lk && (prev_md != int'(exp_divisor));
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge AXI_CLOCK or negedge AXI_RST);
      if (!AXI_RST) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge AXI_CLOCK);
      check("meas_divisor", int'(meas_divisor), m_md);
      check("meas_valid", int'(meas_valid), int'(m_mv));
      check("locked", int'(locked), int'(m_lk));
      check("clk_lost", int'(clk_lost), int'(m_lost));
      check("div_mismatch", int'(div_mismatch), int'(m_mm));
      if (meas_valid === 1'b1) pulses++;
    end
  end

  // Flip sd_clk_in, then hold it for h clocks (divisor h-1).
  task automatic half(input int h);
    sd_clk_in = ~sd_clk_in;
    repeat (h) begin
      @(posedge AXI_CLOCK);
      #1;
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge AXI_CLOCK);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int p0;
    step_clk(3);
    check("rst_meas_divisor", int'(meas_divisor), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_clk_lost", int'(clk_lost), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_div_mismatch", int'(div_mismatch), 0);

    AXI_RST = 1'b1;
    exp_divisor = 8'd4;
    repeat (8) half(5);
    check("d4_meas", int'(meas_divisor), 4);
    check("d4_locked", int'(locked), 1);
    check("d4_mismatch", int'(div_mismatch), 0);
    check("d4_lost", int'(clk_lost), 0);

    exp_divisor = 8'd7;
    step_clk(1);
    check("exp7_mismatch", int'(div_mismatch), 1);
    check("exp7_locked", int'(locked), 1);
    repeat (2) half(5);

    exp_divisor = 8'd9;
    repeat (6) half(10);
    check("d9_meas", int'(meas_divisor), 9);
    check("d9_locked", int'(locked), 1);
    check("d9_mismatch", int'(div_mismatch), 0);

    sd_clk_in = ~sd_clk_in;
    k = 0;
    while (clk_lost !== 1'b1 && k < 400) begin
      step_clk(1);
      k++;
    end
    check("lost_delay", k, TIMEOUT_CYCLES + 3);
    check("lost_locked", int'(locked), 0);
    check("lost_meas_kept", int'(meas_divisor), 9);

    half(10);
    check("resume_lost_clear", int'(clk_lost), 0);
    check("resume_not_locked", int'(locked), 0);
    repeat (4) half(10);
    check("relock", int'(locked), 1);

    exp_divisor = 8'd0;
    repeat (10) half(1);
    check("d0_meas", int'(meas_divisor), 0);
    check("d0_locked", int'(locked), 1);

    exp_divisor = 8'd255;
    repeat (7) half(256);
    check("d255_meas", int'(meas_divisor), 255);
    check("d255_locked", int'(locked), 1);

    @(posedge AXI_CLOCK);
    #3;
    AXI_RST = 1'b0;
    #1;
    check("arst_meas", int'(meas_divisor), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_valid", int'(meas_valid), 0);
    check("arst_lost", int'(clk_lost), 0);
    check("arst_mismatch", int'(div_mismatch), 0);
    sd_clk_in = 1'b0;
    exp_divisor = 8'd4;
    step_clk(2);
    AXI_RST = 1'b1;
    p0 = pulses;
    half(5);
    check("first_toggle_no_sample", pulses - p0, 0);
    half(5);
    check("second_toggle_sample", pulses - p0, 1);
    check("second_toggle_meas", int'(meas_divisor), 4);

    AXI_RST = 1'b0;
    sd_clk_in = 1'b0;
    step_clk(2);
    AXI_RST = 1'b1;
    p0 = pulses;
    repeat (4) half(280);
    check("long_half_no_valid", pulses - p0, 0);
    check("long_half_locked", int'(locked), 0);
    check("long_half_lost", int'(clk_lost), 0);

    step_clk(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
